// File: rtl/stream_stage.sv
// -----------------------------------------------------------------------------
// stream_stage
// One registered valid/ready pipeline stage used for each brancher output.
// Valid and data come straight from flops, so there is no combinational
// path from the input side to the output side.
//
// Parameters
//   WIDTH : payload width held by the stage
//   BURST : "yes" = can take a new beat while the held beat drains
//           (full throughput); "no" = takes a beat only when empty
//
// Ports
//   iCLK   : clock, rising edge
//   iRST   : synchronous active-high reset, clears valid and data
//   iLoad  : capture iData this cycle (the parent only asserts it when oFree)
//   iData  : incoming payload
//   oFree  : stage can accept a beat this cycle (combinational)
//   oValid : downstream valid (registered)
//   iReady : downstream ready
//   oData  : downstream payload (registered)
// -----------------------------------------------------------------------------
module stream_stage #(
  parameter int    WIDTH = 4,
  parameter string BURST = "yes"
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic             oFree,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData
);

  localparam bit BURST_EN = (BURST == "yes");

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             drain_s;

  // Free/drain decode: in burst mode a draining beat frees the slot in the
  // same cycle; otherwise the stage must already be empty.
  always_comb begin
    drain_s = valid_q & iReady;
    if (BURST_EN) begin
      oFree = ~valid_q | iReady;
    end else begin
      oFree = ~valid_q;
    end
  end

  // Next-state: a load wins over a drain so that a simultaneous drain and
  // load keeps valid high with the new beat; data only moves on a load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (iLoad) begin
      valid_d = 1'b1;
      data_d  = iData;
    end else if (drain_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage registers with synchronous reset.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign oValid = valid_q;
  assign oData  = data_q;

endmodule

// File: rtl/brancher.sv
// -----------------------------------------------------------------------------
// brancher
// Routes one upstream valid/ready stream to one of two registered output
// branches chosen per beat by iSelect_AM. The upstream payload carries both
// branch fields packed as {branch-1 field, branch-0 field}; only the field
// of the selected branch is captured.
//
// Parameters
//   WIDTH0 : branch-0 payload width
//   WIDTH1 : branch-1 payload width
//   BURST  : "yes" = full throughput per branch, "no" = one beat per two
//            cycles per branch (stage accepts only when empty)
//
// Ports
//   iCLK        : clock, rising edge
//   iRST        : synchronous active-high reset
//   iValid_AM   : upstream valid
//   oReady_AM   : upstream ready, free flag of the selected branch
//   iSelect_AM  : destination, 0 = branch 0, 1 = branch 1
//   iData_AM    : packed payload {branch-1 field, branch-0 field}
//   oValid_BM0 / iReady_BM0 / oData_BM0 : branch-0 stream
//   oValid_BM1 / iReady_BM1 / oData_BM1 : branch-1 stream
// -----------------------------------------------------------------------------
module brancher #(
  parameter int    WIDTH0 = 4,
  parameter int    WIDTH1 = 4,
  parameter string BURST  = "yes"
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iValid_AM,
  output logic                     oReady_AM,
  input  logic                     iSelect_AM,
  input  logic [WIDTH0+WIDTH1-1:0] iData_AM,
  output logic                     oValid_BM0,
  input  logic                     iReady_BM0,
  output logic [WIDTH0-1:0]        oData_BM0,
  output logic                     oValid_BM1,
  input  logic                     iReady_BM1,
  output logic [WIDTH1-1:0]        oData_BM1
);

  logic              free0_s;
  logic              free1_s;
  logic              accept_s;
  logic              load0_s;
  logic              load1_s;
  logic [WIDTH0-1:0] field0_s;
  logic [WIDTH1-1:0] field1_s;

  // Split the packed payload into the two branch fields.
  assign field0_s = iData_AM[WIDTH0-1:0];
  assign field1_s = iData_AM[WIDTH0+WIDTH1-1:WIDTH0];

  // Upstream ready follows only the selected branch, so a stalled branch
  // never blocks beats headed for the other one.
  always_comb begin
    if (iSelect_AM) begin
      oReady_AM = free1_s;
    end else begin
      oReady_AM = free0_s;
    end
  end

  // Demux the accepted beat to exactly one branch stage.
  always_comb begin
    accept_s = iValid_AM & oReady_AM;
    if (iSelect_AM) begin
      load0_s = 1'b0;
      load1_s = accept_s;
    end else begin
      load0_s = accept_s;
      load1_s = 1'b0;
    end
  end

  stream_stage #(
    .WIDTH (WIDTH0),
    .BURST (BURST)
  ) u_stage0 (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iLoad  (load0_s),
    .iData  (field0_s),
    .oFree  (free0_s),
    .oValid (oValid_BM0),
    .iReady (iReady_BM0),
    .oData  (oData_BM0)
  );

  stream_stage #(
    .WIDTH (WIDTH1),
    .BURST (BURST)
  ) u_stage1 (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iLoad  (load1_s),
    .iData  (field1_s),
    .oFree  (free1_s),
    .oValid (oValid_BM1),
    .iReady (iReady_BM1),
    .oData  (oData_BM1)
  );

endmodule

// File: tb/tb_brancher.sv
// -----------------------------------------------------------------------------
// tb_brancher
// Drives a burst ("yes") and a non-burst ("no") brancher with the same input
// stream and compares both against a per-branch one-slot queue model.
// -----------------------------------------------------------------------------
module tb_brancher;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iValid_AM = 1'b0;
  logic       iSelect_AM = 1'b0;
  logic [7:0] iData_AM = 8'h00;
  logic       iReady_BM0 = 1'b0;
  logic       iReady_BM1 = 1'b0;

  logic       b_rdy, b_v0, b_v1;
  logic [3:0] b_d0, b_d1;
  logic       n_rdy, n_v0, n_v1;
  logic [3:0] n_d0, n_d1;

  int n_vec = 0;
  int n_err = 0;
  int n_acc_obs = 0;

  // model: per (dut, branch) a queue of capacity one plus last loaded value
  logic [3:0] mq   [4][$];
  logic [3:0] last [4];

  always #5 iCLK = ~iCLK;

  brancher dut_b (
    .iCLK(iCLK), .iRST(iRST), .iValid_AM(iValid_AM), .oReady_AM(b_rdy),
    .iSelect_AM(iSelect_AM), .iData_AM(iData_AM),
    .oValid_BM0(b_v0), .iReady_BM0(iReady_BM0), .oData_BM0(b_d0),
    .oValid_BM1(b_v1), .iReady_BM1(iReady_BM1), .oData_BM1(b_d1)
  );

  brancher #(.BURST("no")) dut_n (
    .iCLK(iCLK), .iRST(iRST), .iValid_AM(iValid_AM), .oReady_AM(n_rdy),
    .iSelect_AM(iSelect_AM), .iData_AM(iData_AM),
    .oValid_BM0(n_v0), .iReady_BM0(iReady_BM0), .oData_BM0(n_d0),
    .oValid_BM1(n_v1), .iReady_BM1(iReady_BM1), .oData_BM1(n_d1)
  );

  task automatic chk_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at negedge, check outputs, advance model at posedge.
  task automatic step(input bit rst, input bit vld, input bit sel,
                      input logic [7:0] data, input bit r0, input bit r1);
    bit exp_rdy [2];
    bit rk [2];
    logic [3:0] fld [2];
    @(negedge iCLK);
    iRST = rst; iValid_AM = vld; iSelect_AM = sel; iData_AM = data;
    iReady_BM0 = r0; iReady_BM1 = r1;
    #1;
    rk[0] = r0; rk[1] = r1;
    fld[0] = data[3:0]; fld[1] = data[7:4];
    for (int m = 0; m < 2; m++) begin
      bit fr [2];
      for (int k = 0; k < 2; k++)
        fr[k] = (mq[m*2+k].size() == 0) || (m == 0 && rk[k]);
      exp_rdy[m] = sel ? fr[1] : fr[0];
    end
    chk_eq("b_ready", {7'd0, b_rdy}, {7'd0, exp_rdy[0]});
    chk_eq("b_valid0", {7'd0, b_v0}, {7'd0, mq[0].size() != 0});
    chk_eq("b_valid1", {7'd0, b_v1}, {7'd0, mq[1].size() != 0});
    chk_eq("b_data0", {4'd0, b_d0}, {4'd0, last[0]});
    chk_eq("b_data1", {4'd0, b_d1}, {4'd0, last[1]});
    chk_eq("n_ready", {7'd0, n_rdy}, {7'd0, exp_rdy[1]});
    chk_eq("n_valid0", {7'd0, n_v0}, {7'd0, mq[2].size() != 0});
    chk_eq("n_valid1", {7'd0, n_v1}, {7'd0, mq[3].size() != 0});
    chk_eq("n_data0", {4'd0, n_d0}, {4'd0, last[2]});
    chk_eq("n_data1", {4'd0, n_d1}, {4'd0, last[3]});
    if (vld && n_rdy && !rst) n_acc_obs++;
    @(posedge iCLK);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        last[i] = 4'h0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 2; k++) begin
          int ix = m*2+k;
          if (mq[ix].size() != 0 && rk[k]) void'(mq[ix].pop_front());
          if (vld && exp_rdy[m] && (sel == k[0])) begin
            mq[ix].push_back(fld[k]);
            last[ix] = fld[k];
          end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) last[i] = 4'h0;

    // reset
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
    #1;
    chk_eq("rst_v0", {7'd0, b_v0}, 8'h00);
    chk_eq("rst_v1", {7'd0, b_v1}, 8'h00);
    chk_eq("rst_d0", {4'd0, b_d0}, 8'h00);
    chk_eq("rst_d1", {4'd0, b_d1}, 8'h00);
    chk_eq("rst_ready", {7'd0, b_rdy}, 8'h01);

    // burst on branch 0
    step(1'b0, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0);
    #1 chk_eq("burst_a", {4'd0, b_d0}, 8'h0A);
    step(1'b0, 1'b1, 1'b0, 8'h0B, 1'b1, 1'b0);
    #1 chk_eq("burst_b", {4'd0, b_d0}, 8'h0B);
    chk_eq("burst_rdy", {7'd0, b_rdy}, 8'h01);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // branch 1 held until ready
    step(1'b0, 1'b1, 1'b1, 8'h70, 1'b0, 1'b0);
    #1 chk_eq("br1_data", {4'd0, b_d1}, 8'h07);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    #1 chk_eq("br1_drained", {7'd0, b_v1}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // backpressure on branch 0
    step(1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h50, 1'b0, 1'b0);
    #1 chk_eq("bp_ready", {7'd0, b_rdy}, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #1 chk_eq("bp_drained", {7'd0, b_v0}, 8'h00);

    // independence: branch 0 stalled, branch 1 still accepts
    step(1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
    #1 chk_eq("indep_d1", {4'd0, b_d1}, 8'h03);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // non-burst: continuous valid gives one beat every two cycles
    n_acc_obs = 0;
    for (int i = 0; i < 8; i++)
      step(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b1, 1'b0);
    chk_eq("noburst_beats", 8'(n_acc_obs), 8'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom),
           8'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/brancher.md
BRANCHER -- requirements
Module: brancher

Interface
REQ-001 SHALL have parameter WIDTH0, default 4, meaning payload width routed to branch 0.
REQ-002 SHALL have parameter WIDTH1, default 4, meaning payload width routed to branch 1.
REQ-003 SHALL have parameter BURST, default "yes"; "yes" = full-throughput, "no" = accept only into an empty stage.
REQ-004 SHALL have port iCLK, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port iRST, input, 1, synchronous active-high reset.
REQ-006 SHALL have port iValid_AM, input, 1, upstream valid.
REQ-007 SHALL have port oReady_AM, output, 1, upstream ready.
REQ-008 SHALL have port iSelect_AM, input, 1, destination select (0 = branch 0, 1 = branch 1).
REQ-009 SHALL have port iData_AM, input, WIDTH0+WIDTH1, packed payload {branch-1 field, branch-0 field}.
REQ-010 SHALL have ports oValid_BM0 (output, 1), iReady_BM0 (input, 1) and oData_BM0 (output, WIDTH0): branch-0 stream.
REQ-011 SHALL have ports oValid_BM1 (output, 1), iReady_BM1 (input, 1) and oData_BM1 (output, WIDTH1): branch-1 stream.

Function
REQ-012 SHALL hold one registered stage per branch: valid flag vK plus data register dK.
REQ-013 SHALL drive oValid_BMk = vk and oData_BMk = dk directly from registers; no combinational input-to-output data path.
REQ-014 SHALL define branch-k free: BURST="yes": !vk | iReady_BMk; BURST="no": !vk.
REQ-015 SHALL drive oReady_AM = free of branch selected by iSelect_AM (combinational).
REQ-016 SHALL accept a transfer when iValid_AM & oReady_AM; select 0 loads d0 <= iData_AM[WIDTH0-1:0], sets v0; select 1 loads d1 <= iData_AM[WIDTH0+WIDTH1-1:WIDTH0], sets v1.
REQ-017 SHALL ignore the unselected payload field.
REQ-018 SHALL clear vk on output handshake (vk & iReady_BMk) when no new accept targets branch k in the same cycle.
REQ-019 SHALL, on simultaneous drain and accept of branch k (BURST="yes" only), keep vk=1 and load new data: one transfer per cycle, latency 1 cycle.
REQ-020 SHALL keep dk and vk stable while vk=1 and iReady_BMk=0 (backpressure holds data).
REQ-021 SHALL let branches operate independently; a stalled branch SHALL NOT block accepts to the other branch.
REQ-022 SHALL, with BURST="no", sustain at most one transfer per two cycles per branch.
REQ-023 SHALL leave dk unchanged when not loading; iData_AM changes without valid SHALL have no effect.

Reset
REQ-024 SHALL, when iRST=1 at a clock edge, clear v0, v1, d0 and d1 to 0; outputs oValid_BM0/1 = 0, oData_BM0/1 = 0.
REQ-025 SHALL discard held data on reset mid-operation; oReady_AM SHALL be 1 in the cycle after reset.

Structure
REQ-026 SHALL need no shared package; parameters are local.
REQ-027 SHALL implement the per-branch stage as one sub-module, stream_stage (params WIDTH, BURST), instantiated twice; brancher adds select/demux logic.

Verification
REQ-028 SHALL verify reset: after iRST, oValid_BM0=oValid_BM1=0, oData=0, oReady_AM=1.
REQ-029 SHALL verify burst branch 0 (BURST="yes"): send sel=0 data 8'h0A, then 8'h0B with iReady_BM0=1 -> oData_BM0=4'hA then 4'hB on consecutive cycles, oReady_AM stays 1.
REQ-030 SHALL verify branch 1: sel=1 data 8'h70 with readies 0 -> oValid_BM1=1, oData_BM1=4'h7 held until iReady_BM1=1, then oValid_BM1=0; oValid_BM0 stays 0.
REQ-031 SHALL verify backpressure: sel=0 data 8'h50, iReady_BM0=0 for 3 cycles -> oData_BM0=4'h0 and oValid_BM0=1 held, oReady_AM=0 for sel=0; iReady_BM0=1 -> drains next cycle.
REQ-032 SHALL verify independence: branch 0 stalled full, sel=1 data 8'h30 -> accepted, oData_BM1=4'h3.
REQ-033 SHALL verify BURST="no": continuous valid with iReady_BM0=1 -> oReady_AM alternates 1/0, one beat every 2 cycles.
